// File: rtl/sprite_move_ctrl_if.sv
// Pixel-path bundle between the VGA timing/colour logic and the sprite controller.
interface sprite_move_ctrl_if;
    logic       frame_start;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] bg_index;
    logic [7:0] index_out;

    modport master (
        output frame_start,
        output pixel_x,
        output pixel_y,
        output bg_index,
        input  index_out
    );

    modport slave (
        input  frame_start,
        input  pixel_x,
        input  pixel_y,
        input  bg_index,
        output index_out
    );
endinterface

// File: rtl/sprite_move_ctrl.sv
// Button-driven 100x100 square overlay: debounced buttons step a clamped shadow position,
// committed to the displayed position at frame start, then used for per-pixel index select.
module sprite_move_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned SIZE       = 100,
    parameter int unsigned INIT_X     = 100,
    parameter int unsigned INIT_Y     = 100,
    parameter int unsigned STEP       = 1,
    parameter int unsigned TICK_DIV   = 1000000,
    parameter int unsigned DEB_CYCLES = 250000,
    parameter logic [7:0]  SQ_INDEX   = 8'd2
) (
    input  logic                     iVGA_CLK,
    input  logic                     iRST_n,
    input  logic                     up,
    input  logic                     down,
    input  logic                     left,
    input  logic                     right,
    sprite_move_ctrl_if.slave        vga,
    output logic [9:0]               x_pos,
    output logic [9:0]               y_pos,
    output logic                     move_tick
);

    localparam int unsigned POS_W  = 10;
    localparam int unsigned EXT_W  = 11;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned N_BTN  = 4;
    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned X_MAX  = H_ACTIVE - SIZE;
    localparam int unsigned Y_MAX  = V_ACTIVE - SIZE;
    localparam int unsigned BTN_UP = 3;
    localparam int unsigned BTN_DN = 2;
    localparam int unsigned BTN_LT = 1;
    localparam int unsigned BTN_RT = 0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } state_t;

    logic [N_BTN-1:0]  r_sync1;
    logic [N_BTN-1:0]  r_sync2;
    logic [N_BTN-1:0]  w_deb;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic              r_move_tick;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_apply;
    logic [POS_W-1:0]  r_sx;
    logic [POS_W-1:0]  r_sy;
    logic [POS_W-1:0]  w_sx_nxt;
    logic [POS_W-1:0]  w_sy_nxt;
    logic [POS_W-1:0]  r_x_pos;
    logic [POS_W-1:0]  r_y_pos;
    logic [EXT_W-1:0]  w_sx_ext;
    logic [EXT_W-1:0]  w_sy_ext;
    logic [EXT_W-1:0]  w_sx_inc;
    logic [EXT_W-1:0]  w_sy_inc;
    logic [EXT_W-1:0]  w_px;
    logic [EXT_W-1:0]  w_py;
    logic [EXT_W-1:0]  w_x0;
    logic [EXT_W-1:0]  w_y0;
    logic [EXT_W-1:0]  w_x1;
    logic [EXT_W-1:0]  w_y1;
    logic              w_inside;
    logic [IDX_W-1:0]  r_index;

    // Two-flop synchroniser; idle level is 1 (released)
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {up, down, left, right};
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_deb
        logic [DEB_W-1:0] r_cnt;
        logic             r_deb;

        // Flip only after DEB_CYCLES consecutive cycles of disagreement
        always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
            if (!iRST_n) begin
                r_cnt <= '0;
                r_deb <= 1'b1;
            end else if (r_sync2[g] != r_deb) begin
                if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    r_deb <= ~r_deb;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_deb[g] = r_deb;
    end

    assign w_tick_nxt = (r_tick_cnt == TICK_W'(TICK_DIV - 1)) ? '0 : r_tick_cnt + 1'b1;

    // move_tick registered from the next count so it lines up with count == TICK_DIV-1
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_tick_cnt  <= '0;
            r_move_tick <= 1'b0;
        end else begin
            r_tick_cnt  <= w_tick_nxt;
            r_move_tick <= (w_tick_nxt == TICK_W'(TICK_DIV - 1));
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_move_tick) begin
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_sx_ext = {1'b0, r_sx};
    assign w_sy_ext = {1'b0, r_sy};
    assign w_sx_inc = w_sx_ext + EXT_W'(STEP);
    assign w_sy_inc = w_sy_ext + EXT_W'(STEP);

    // One direction per tick, up > down > left > right, saturating at the screen edges
    always_comb begin
        w_sx_nxt = r_sx;
        w_sy_nxt = r_sy;
        if (!w_deb[BTN_UP]) begin
            w_sy_nxt = (w_sy_ext >= EXT_W'(STEP)) ? POS_W'(w_sy_ext - EXT_W'(STEP)) : '0;
        end else if (!w_deb[BTN_DN]) begin
            w_sy_nxt = (w_sy_inc > EXT_W'(Y_MAX)) ? POS_W'(Y_MAX) : POS_W'(w_sy_inc);
        end else if (!w_deb[BTN_LT]) begin
            w_sx_nxt = (w_sx_ext >= EXT_W'(STEP)) ? POS_W'(w_sx_ext - EXT_W'(STEP)) : '0;
        end else if (!w_deb[BTN_RT]) begin
            w_sx_nxt = (w_sx_inc > EXT_W'(X_MAX)) ? POS_W'(X_MAX) : POS_W'(w_sx_inc);
        end
    end

    // Shadow and displayed position; a coincident commit sees the pre-update shadow
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_sx    <= POS_W'(INIT_X);
            r_sy    <= POS_W'(INIT_Y);
            r_x_pos <= POS_W'(INIT_X);
            r_y_pos <= POS_W'(INIT_Y);
        end else begin
            if (w_apply) begin
                r_sx <= w_sx_nxt;
                r_sy <= w_sy_nxt;
            end
            if (vga.frame_start) begin
                r_x_pos <= r_sx;
                r_y_pos <= r_sy;
            end
        end
    end

    assign w_px     = {1'b0, vga.pixel_x};
    assign w_py     = {1'b0, vga.pixel_y};
    assign w_x0     = {1'b0, r_x_pos};
    assign w_y0     = {1'b0, r_y_pos};
    assign w_x1     = w_x0 + EXT_W'(SIZE);
    assign w_y1     = w_y0 + EXT_W'(SIZE);
    assign w_inside = (w_px >= w_x0) && (w_px < w_x1) && (w_py >= w_y0) && (w_py < w_y1);

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_index <= '0;
        end else begin
            r_index <= w_inside ? SQ_INDEX : vga.bg_index;
        end
    end

    assign vga.index_out = r_index;
    assign x_pos         = r_x_pos;
    assign y_pos         = r_y_pos;
    assign move_tick     = r_move_tick;

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Directed bench for sprite_move_ctrl with TICK_DIV=8, DEB_CYCLES=4; cyc counts rising edges since reset release.
module tb_sprite_move_ctrl;

    logic       clk;
    logic       rst_n;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       move_tick;

    int n_vec;
    int n_err;
    int cyc;

    sprite_move_ctrl_if vga_if ();

    sprite_move_ctrl #(
        .TICK_DIV   (8),
        .DEB_CYCLES (4)
    ) dut (
        .iVGA_CLK  (clk),
        .iRST_n    (rst_n),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .vga       (vga_if),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .move_tick (move_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge that follows rising edge number n
    task automatic adv_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    // Assert reset between edges, check the asynchronous reset values, release before edge 0
    task automatic do_reset(input string tag);
        up    = 1'b1;
        down  = 1'b1;
        left  = 1'b1;
        right = 1'b1;
        rst_n = 1'b0;
        #1;
        check({tag, "_x"},   32'(x_pos), 32'd100);
        check({tag, "_y"},   32'(y_pos), 32'd100);
        check({tag, "_idx"}, 32'(vga_if.index_out), 32'd0);
        check({tag, "_mt"},  32'(move_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
    endtask

    // frame_start high in the cycle after edge n, commit lands on edge n+1
    task automatic commit_at(input int n);
        adv_to(n);
        vga_if.frame_start = 1'b1;
        adv_to(n + 1);
        vga_if.frame_start = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input int bg, input int exp, input string tag);
        vga_if.pixel_x  = 10'(px);
        vga_if.pixel_y  = 10'(py);
        vga_if.bg_index = 8'(bg);
        adv_to(cyc + 1);
        check(tag, 32'(vga_if.index_out), 32'(exp));
    endtask

    initial begin
        int exp_y [5] = '{1, 0, 0, 0, 0};
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        up    = 1'b1;
        down  = 1'b1;
        left  = 1'b1;
        right = 1'b1;
        vga_if.frame_start = 1'b0;
        vga_if.pixel_x     = 10'd0;
        vga_if.pixel_y     = 10'd0;
        vga_if.bg_index    = 8'd7;
        @(negedge clk);

        // Debounce: right held 20 cycles spans the shadow updates at edges 8, 16, 24
        do_reset("rst0");
        right = 1'b0;
        adv_to(5);
        check("tick_pre", 32'(move_tick), 32'd0);
        adv_to(6);
        check("tick_hi", 32'(move_tick), 32'd1);
        adv_to(7);
        check("tick_post", 32'(move_tick), 32'd0);
        adv_to(19);
        right = 1'b1;
        adv_to(30);
        check("deb_nocommit_x", 32'(x_pos), 32'd100);
        commit_at(30);
        check("deb_x", 32'(x_pos), 32'd103);
        check("deb_y", 32'(y_pos), 32'd100);
        adv_to(32);
        right = 1'b0;
        adv_to(35);
        right = 1'b1;
        commit_at(46);
        check("glitch_x", 32'(x_pos), 32'd103);

        // Reset in the APPLY cycle discards the pending move
        do_reset("rst1");
        right = 1'b0;
        commit_at(16);
        check("pre_rst_x", 32'(x_pos), 32'd102);
        adv_to(23);
        check("pre_rst_idx", 32'(vga_if.index_out), 32'd7);
        do_reset("rst_apply");
        commit_at(30);
        check("post_rst_x", 32'(x_pos), 32'd100);
        check("post_rst_y", 32'(y_pos), 32'd100);

        // Priority: up wins over left, sy saturates at 0
        do_reset("rst2");
        up = 1'b0;
        adv_to(780);
        left = 1'b0;
        commit_at(784);
        check("prio_y2", 32'(y_pos), 32'd2);
        for (int k = 0; k < 5; k++) begin
            commit_at(8 * (99 + k));
            check($sformatf("prio_y_t%0d", k), 32'(y_pos), 32'(exp_y[k]));
            check($sformatf("prio_x_t%0d", k), 32'(x_pos), 32'd100);
        end
        up   = 1'b1;
        left = 1'b1;

        // Right and down limits: 540 and 380, no wrap
        do_reset("rst3");
        right = 1'b0;
        commit_at(8 * 439);
        check("xmax_539", 32'(x_pos), 32'd539);
        commit_at(8 * 440);
        check("xmax_540", 32'(x_pos), 32'd540);
        commit_at(8 * 445);
        check("xmax_hold", 32'(x_pos), 32'd540);
        right = 1'b1;
        down  = 1'b0;
        commit_at(8 * 724);
        check("ymax_379", 32'(y_pos), 32'd379);
        commit_at(8 * 725);
        check("ymax_380", 32'(y_pos), 32'd380);
        commit_at(8 * 730);
        check("ymax_hold", 32'(y_pos), 32'd380);
        check("ymax_x", 32'(x_pos), 32'd540);
        down = 1'b1;

        // Commit coinciding with the APPLY update takes the old shadow
        do_reset("rst4");
        adv_to(45);
        right = 1'b0;
        adv_to(52);
        right = 1'b1;
        adv_to(54);
        check("race_tick", 32'(move_tick), 32'd1);
        commit_at(55);
        check("race_old_x", 32'(x_pos), 32'd100);
        commit_at(60);
        check("race_new_x", 32'(x_pos), 32'd101);

        // Pixel select around the square at (100,100)
        do_reset("rst5");
        pix(100, 100, 7, 2, "px_tl");
        pix(199, 199, 7, 2, "px_br");
        pix(200, 150, 7, 7, "px_right_out");
        pix(99,  150, 7, 7, "px_left_out");
        pix(150, 99,  7, 7, "px_top_out");
        pix(150, 200, 7, 7, "px_bot_out");
        pix(150, 150, 9, 2, "px_mid");
        pix(300, 300, 5, 5, "px_far");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_move_ctrl.md
# sprite_move_ctrl

Sequences position updates for the 100x100 square overlay on the VGA pixel path. Raw active-low push-buttons are synchronised and debounced, and a fixed-rate move tick turns them into a clamped shadow position. That position is committed to the displayed position only at frame start, so no frame tears. Per pixel, the block selects either the background palette index or the square index, and feeds the colour-table lookup.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SIZE, 100, square edge in pixels
- INIT_X, 100, reset x position
- INIT_Y, 100, reset y position
- STEP, 1, pixels moved per tick
- TICK_DIV, 1000000, clock cycles per move tick
- DEB_CYCLES, 250000, cycles a synchronised button must be stable before its debounced state changes
- SQ_INDEX, 8'd2, palette index driven inside the square

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on its rising edge
- iRST_n  in  1  reset; asynchronous and active-low
- up, down, left, right  in  1 each  raw buttons, active-low, asynchronous to iVGA_CLK
- frame_start  in  1  one-cycle pulse at the start of each frame, during vertical blank
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- bg_index  in  8  background palette index for the current pixel
- index_out  out  8  registered palette index to the colour table
- x_pos  out  10  displayed square x (top-left)
- y_pos  out  10  displayed square y (top-left)
- move_tick  out  1  one-cycle pulse each time a move tick occurs

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser. Flops reset to 1, meaning released.
- **Debounce:** one counter per button.
  - When the synchronised value differs from the debounced value, the counter increments; otherwise it clears.
  - When the counter reaches DEB_CYCLES-1, the debounced value flips and the counter clears.
  - Debounced values reset to 1.
- **Tick counter:** counts 0..TICK_DIV-1 and wraps. move_tick is 1 in the cycle the counter equals TICK_DIV-1.
- **Move FSM:** states IDLE and APPLY.
  - IDLE: on move_tick, go to APPLY.
  - APPLY: update the shadow position (sx, sy) once, then return to IDLE.
  - Only one direction is applied per tick, with priority up > down > left > right. Only pressed (debounced 0) buttons count.
- **Clamped arithmetic:** computed at 11 bits.
  - up: sy = (sy >= STEP) ? sy-STEP : 0.
  - down: sy = min(sy+STEP, V_ACTIVE-SIZE).
  - left and right: same rules on sx, with limit H_ACTIVE-SIZE.
- **Commit:** on frame_start, x_pos/y_pos take sx/sy.
- **Pixel select:** the pixel is inside the square when x_pos <= pixel_x < x_pos+SIZE and y_pos <= pixel_y < y_pos+SIZE, compared at 11 bits. index_out = inside ? SQ_INDEX : bg_index, registered.

## Timing
- **Reset values:**
  - index_out = 0, move_tick = 0, FSM = IDLE, tick counter = 0.
  - x_pos = sx = INIT_X, y_pos = sy = INIT_Y.
  - Debounce counters = 0.
- **Button latency:** a button held from cycle 0 takes 2 sync cycles plus DEB_CYCLES cycles before its debounced value changes. A glitch shorter than DEB_CYCLES clears the counter and produces no change.
- **Shadow update:** move_tick at cycle t gives the FSM APPLY at t+1 and the new sx/sy visible at t+2.
- **Display latency:** x_pos/y_pos change only in the cycle after frame_start.
- **frame_start coinciding with the APPLY update:** the commit takes the pre-update sx/sy. The update appears at the next frame.
- **index_out latency:** 1 cycle from pixel_x/pixel_y/bg_index.
- **Reset asserted mid-APPLY:** the update is discarded and all state returns to its reset value immediately.
- **Boundaries:**
  - At sx=0 with left pressed, sx stays 0.
  - At sx=540 with right pressed, sx stays 540.
  - The same holds for sy at 0 and 380.
  - Never wraps.

## Test plan
1. **Reset value check:**
   - Stimulus: assert iRST_n=0 mid-run.
   - Required: x_pos=100, y_pos=100 and index_out=0 asynchronously; move_tick=0.
2. **Debounce:**
   - Stimulus: TICK_DIV=8, DEB_CYCLES=4. Hold right low for 20 cycles, pulse frame_start after 3 ticks.
   - Required: x_pos=103, y_pos=100.
   - Stimulus: a 3-cycle low glitch on right.
   - Required: no change.
3. **Priority:**
   - Stimulus: up and left both held for 5 ticks from sy=2, STEP=1.
   - Required: sy goes 1, 0, 0, 0, 0; sx unchanged.
4. **Commit race:**
   - Stimulus: frame_start in the same cycle as the APPLY update moving sx 100→101.
   - Required: x_pos=100 after that frame_start and 101 after the next one.
5. **Pixel select:**
   - Stimulus: x_pos=y_pos=100, bg_index=7.
   - Required, each one cycle later:
     - (100,100) gives 2.
     - (199,199) gives 2.
     - (200,150) gives 7.
     - (99,150) gives 7.
